fft_mem_reader: RTL and testbench

- Read-side sequencer for the FFT ping-pong sample memory.
- On `start`, selects one bank through `rmem_id` and walks all `FFT_SIZE` addresses, reading two samples per cycle on dual read ports A and B.
- Returns the 1-cycle-latency memory data as a valid/ready stream with `last`, using an internal skid FIFO so backpressure never drops a beat.
- Sits between the memory mux and the output/DMA logic; it is the counterpart of the FFT write path (`waddra/b`, `wea/b`, `wmem_id`).

---
 rtl/fft_mem_pkg.sv | 33 +++
 rtl/fft_mem_reader_if.sv | 37 +++
 rtl/fft_rd_skid.sv | 102 ++++++++++
 rtl/fft_mem_reader.sv | 172 +++++++++++++++++
 tb/tb_fft_mem_reader.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fft_mem_pkg.sv
// Shared definitions for the FFT sample-memory read path: default frame
// geometry, default address/data types, read-sequencer state encoding and
// the address bit-reversal helper.
package fft_mem_pkg;

    localparam int DEF_FFT_SIZE     = 4096;
    localparam int DEF_SAMPLE_WIDTH = 16;
    localparam int DEF_SKID_DEPTH   = 4;
    localparam int DEF_ADDR_WIDTH   = $clog2(DEF_FFT_SIZE);
    localparam int DEF_DATA_WIDTH   = 2 * DEF_SAMPLE_WIDTH;

    typedef logic [DEF_ADDR_WIDTH-1:0] addr_t;
    typedef logic [DEF_DATA_WIDTH-1:0] data_t;

    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_READ  = 2'd1,
        RD_DRAIN = 2'd2
    } rd_state_e;

    // Reverse the low 'w' bits of v; bits at and above w come back as zero.
    function automatic logic [31:0] bit_rev(input logic [31:0] v, input int w);
        logic [31:0] r;
        r = 32'd0;
        for (int i = 0; i < 32; i++) begin
            if (i < w) begin
                r[5'(i)] = v[5'(w - 1 - i)];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_mem_reader_if.sv
// Bundle of the read-sequencer control, dual-port memory read and output
// stream signals. master = the reader, slave = its environment.
interface fft_mem_reader_if
    import fft_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
    logic                  start;
    logic                  mem_sel;
    logic                  rmem_id;
    logic [ADDR_WIDTH-1:0] fft_raddra;
    logic [ADDR_WIDTH-1:0] fft_raddrb;
    logic                  fft_rea;
    logic                  fft_reb;
    logic [DATA_WIDTH-1:0] fft_rdataa;
    logic [DATA_WIDTH-1:0] fft_rdatab;
    logic [DATA_WIDTH-1:0] out_dataa;
    logic [DATA_WIDTH-1:0] out_datab;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_last;
    logic                  busy;
    logic                  done;

    modport master (
        input  start, mem_sel, fft_rdataa, fft_rdatab, out_ready,
        output rmem_id, fft_raddra, fft_raddrb, fft_rea, fft_reb,
               out_dataa, out_datab, out_valid, out_last, busy, done
    );

    modport slave (
        output start, mem_sel, fft_rdataa, fft_rdatab, out_ready,
        input  rmem_id, fft_raddra, fft_raddrb, fft_rea, fft_reb,
               out_dataa, out_datab, out_valid, out_last, busy, done
    );
endinterface

// File: rtl/fft_rd_skid.sv
// Small synchronous FIFO absorbing memory read data while the consumer
// stalls. Pointers wrap modulo DEPTH, so DEPTH need not be a power of two.
module fft_rd_skid #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             din_i,
    input  logic                         pop_i,
    output logic [WIDTH-1:0]             dout_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         empty_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full_s, push_s, pop_s;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return '0;
        end else begin
            return p + PW'(1);
        end
    endfunction

    assign full_s  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push_s  = push_i && !full_s;
    assign pop_s   = pop_i && !empty_o;
    assign dout_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Next pointer and occupancy; push and pop together leave occupancy alone.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage; cleared on reset so the head payload reads zero when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_s) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    fft_rd_skid_chk u_chk (
        .clk    (clk),
        .rst    (rst),
        .push_i (push_i),
        .full_i (full_s)
    );
endmodule

// Upstream credit accounting must make a push into a full FIFO impossible.
module fft_rd_skid_chk (
    input logic clk,
    input logic rst,
    input logic push_i,
    input logic full_i
);
    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push_i && full_i));
endmodule

// File: rtl/fft_mem_reader.sv
// Read-side sequencer for the FFT ping-pong sample memory. Latches a bank,
// walks the frame two samples per cycle and streams the data out through a
// credit-controlled skid FIFO. Define FFT_RD_BITREV_EN to issue bit-reversed
// addresses instead of natural order.
module fft_mem_reader
    import fft_mem_pkg::*;
#(
    parameter int FFT_SIZE     = DEF_FFT_SIZE,
    parameter int SAMPLE_WIDTH = DEF_SAMPLE_WIDTH,
    parameter int SKID_DEPTH   = DEF_SKID_DEPTH
) (
    input logic              clk,
    input logic              rst,
    fft_mem_reader_if.master bus
);
    localparam int AW = $clog2(FFT_SIZE);
    localparam int DW = 2 * SAMPLE_WIDTH;
    localparam int KW = AW - 1;
    localparam int CW = $clog2(SKID_DEPTH + 1);
    localparam int PN = CW + 2;

    localparam logic [1:0]    S_IDLE  = RD_IDLE;
    localparam logic [1:0]    S_READ  = RD_READ;
    localparam logic [1:0]    S_DRAIN = RD_DRAIN;
    localparam logic [KW-1:0] K_MAX   = {KW{1'b1}};

    logic [1:0]    state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic          rmem_id_q, rmem_id_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          rea_q, rea_d;
    logic          rlast_q, rlast_d;
    logic [AW-1:0] raddra_q, raddra_d;
    logic [AW-1:0] raddrb_q, raddrb_d;
    logic          inflight_q, inflight_last_q;

    logic [KW-1:0]     issue_k_s;
    logic              issue_s, credit_ok_s, pop_s, empty_s;
    logic [AW-1:0]     addr_a_s, addr_b_s;
    logic [CW-1:0]     count_s;
    logic [PN-1:0]     pending_s;
    logic [2*DW:0]     head_s;

    // A frame always begins at k = 0 when launched from IDLE.
    assign issue_k_s = (state_q == S_IDLE) ? '0 : k_q;

`ifdef FFT_RD_BITREV_EN
    assign addr_a_s = AW'(bit_rev(32'({issue_k_s, 1'b0}), AW));
    assign addr_b_s = AW'(bit_rev(32'({issue_k_s, 1'b1}), AW));
`else
    assign addr_a_s = {issue_k_s, 1'b0};
    assign addr_b_s = {issue_k_s, 1'b1};
`endif

    // Everything already committed to the FIFO after this edge: current
    // contents less a pop, plus the beat in flight and the read just issued.
    assign pending_s   = PN'(count_s) + PN'(inflight_q) + PN'(rea_q) - PN'(pop_s);
    assign credit_ok_s = (pending_s < PN'(SKID_DEPTH));
    assign issue_s     = ((state_q == S_IDLE) && bus.start) ||
                         ((state_q == S_READ) && credit_ok_s);
    assign pop_s       = !empty_s && bus.out_ready;

    // Sequencer next state: bank latch, read issue and frame completion.
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        rmem_id_d = rmem_id_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        rea_d     = 1'b0;
        rlast_d   = 1'b0;
        raddra_d  = raddra_q;
        raddrb_d  = raddrb_q;
        if (issue_s) begin
            rea_d    = 1'b1;
            rlast_d  = (issue_k_s == K_MAX);
            raddra_d = addr_a_s;
            raddrb_d = addr_b_s;
            k_d      = issue_k_s + KW'(1);
        end else begin
            k_d = k_q;
        end
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    rmem_id_d = bus.mem_sel;
                    busy_d    = 1'b1;
                    state_d   = S_READ;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_READ: begin
                if (credit_ok_s && (k_q == K_MAX)) begin
                    state_d = S_DRAIN;
                end else begin
                    state_d = S_READ;
                end
            end
            S_DRAIN: begin
                if (!rea_q && !inflight_q &&
                    ((count_s == '0) || ((count_s == CW'(1)) && pop_s))) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Sequencer registers and the one-cycle in-flight stage of the memory.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= S_IDLE;
            k_q             <= '0;
            rmem_id_q       <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            rea_q           <= 1'b0;
            rlast_q         <= 1'b0;
            raddra_q        <= '0;
            raddrb_q        <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            k_q             <= k_d;
            rmem_id_q       <= rmem_id_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            rea_q           <= rea_d;
            rlast_q         <= rlast_d;
            raddra_q        <= raddra_d;
            raddrb_q        <= raddrb_d;
            inflight_q      <= rea_q;
            inflight_last_q <= rlast_q;
        end
    end

    fft_rd_skid #(
        .WIDTH (2 * DW + 1),
        .DEPTH (SKID_DEPTH)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .push_i  (inflight_q),
        .din_i   ({inflight_last_q, bus.fft_rdataa, bus.fft_rdatab}),
        .pop_i   (pop_s),
        .dout_o  (head_s),
        .count_o (count_s),
        .empty_o (empty_s)
    );

    assign bus.rmem_id    = rmem_id_q;
    assign bus.fft_raddra = raddra_q;
    assign bus.fft_raddrb = raddrb_q;
    assign bus.fft_rea    = rea_q;
    assign bus.fft_reb    = rea_q;
    assign bus.out_valid  = !empty_s;
    assign bus.out_last   = head_s[2*DW];
    assign bus.out_dataa  = head_s[2*DW-1:DW];
    assign bus.out_datab  = head_s[DW-1:0];
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
endmodule

// File: tb/tb_fft_mem_reader.sv
// Self-checking bench for fft_mem_reader with FFT_SIZE=16, SKID_DEPTH=4.
// Memory banks hold random words; expected beats are derived from the
// frame addressing rule (natural, or bit-reversed under FFT_RD_BITREV_EN).
module tb_fft_mem_reader;
    localparam int FFT_SIZE = 16;
    localparam int AW       = 4;
    localparam int DW       = 32;
    localparam int DEPTH    = 4;
    localparam int BEATS    = FFT_SIZE / 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fft_mem_reader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    fft_mem_reader #(
        .FFT_SIZE     (FFT_SIZE),
        .SAMPLE_WIDTH (16),
        .SKID_DEPTH   (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [DW-1:0] mem [2][FFT_SIZE];
    int total = 0;
    int bad   = 0;
    int rd_count = 0;
    int en_split = 0;

    // Memory model: one-cycle read latency from the bank selected by rmem_id.
    always @(posedge clk) begin
        if (bus.fft_rea) bus.fft_rdataa <= mem[bus.rmem_id][bus.fft_raddra];
        if (bus.fft_reb) bus.fft_rdatab <= mem[bus.rmem_id][bus.fft_raddrb];
    end

    // Count issued reads and watch that both enables move together.
    always @(posedge clk) begin
        if (bus.fft_rea) rd_count++;
        if (bus.fft_rea !== bus.fft_reb) en_split++;
    end

    logic [DW-1:0] got_a[$];
    logic [DW-1:0] got_b[$];
    logic          got_last[$];
    int first_valid_cyc, last_hs_cyc, done_cyc, done_seen;
    int stall_err, outst_err, rd_base, rd_at20, rea_at20;

    function automatic int exp_addr(input int k, input int port);
        int a;
        int r;
        a = 2 * k + port;
        r = a;
`ifdef FFT_RD_BITREV_EN
        r = 0;
        for (int i = 0; i < AW; i++) begin
            if (((a >> i) & 1) == 1) r = r | (1 << (AW - 1 - i));
        end
`endif
        return r;
    endfunction

    // Number of collected beats that disagree with the expected frame.
    function automatic int beat_errors(input int bank);
        int e;
        e = 0;
        if (got_a.size() != BEATS) return 100 + got_a.size();
        for (int j = 0; j < BEATS; j++) begin
            if (got_a[j] !== mem[bank][exp_addr(j, 0)]) e++;
            if (got_b[j] !== mem[bank][exp_addr(j, 1)]) e++;
            if (got_last[j] !== (j == BEATS - 1)) e++;
        end
        return e;
    endfunction

    task automatic start_frame(input logic bank);
        bus.mem_sel = bank;
        bus.start   = 1'b1;
        rd_base     = rd_count;
        @(posedge clk); #1;
        bus.start   = 1'b0;
    endtask

    // Consumer: drives out_ready by mode and records beats and timing.
    // mode 0 always ready, 1 toggling, 2 random, 3 low for cycles 1..20.
    task automatic consume(input int mode, input int limit, input int inj_cyc, input int abort_beats);
        logic          prev_stall, rdy, pl;
        logic [DW-1:0] pa, pb;
        got_a.delete(); got_b.delete(); got_last.delete();
        first_valid_cyc = -1; last_hs_cyc = -1; done_cyc = -1; done_seen = 0;
        stall_err = 0; outst_err = 0; rd_at20 = -1; rea_at20 = -1;
        prev_stall = 1'b0; pa = '0; pb = '0; pl = 1'b0;
        for (int cyc = 1; cyc <= limit; cyc++) begin
            if (bus.done) begin
                done_cyc = cyc; done_seen = 1;
                break;
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = cyc[0];
                2:       rdy = 1'($urandom_range(0, 1));
                default: rdy = (cyc > 20);
            endcase
            bus.out_ready = rdy;
            if (cyc == inj_cyc) begin
                bus.start = 1'b1; bus.mem_sel = 1'b0;
            end else begin
                bus.start = 1'b0;
            end
            if (cyc == 20) begin
                rd_at20  = rd_count - rd_base;
                rea_at20 = int'(bus.fft_rea);
            end
            if (bus.out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (prev_stall && (!bus.out_valid || bus.out_dataa !== pa ||
                               bus.out_datab !== pb || bus.out_last !== pl)) stall_err++;
            if ((rd_count - rd_base) + int'(bus.fft_rea) - got_a.size() > DEPTH) outst_err++;
            if (bus.out_valid && rdy) begin
                got_a.push_back(bus.out_dataa);
                got_b.push_back(bus.out_datab);
                got_last.push_back(bus.out_last);
                last_hs_cyc = cyc;
            end
            prev_stall = bus.out_valid && !rdy;
            pa = bus.out_dataa; pb = bus.out_datab; pl = bus.out_last;
            if (abort_beats > 0 && got_a.size() >= abort_beats) break;
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        logic [3*AW+2*DW+7:0] outs;
        outs = {bus.rmem_id, bus.fft_raddra, bus.fft_raddrb, bus.fft_rea, bus.fft_reb,
                bus.out_dataa, bus.out_datab, bus.out_valid, bus.out_last, bus.busy, bus.done, 1'b0, AW'(0)};
        total++;
        if (outs !== '0) begin
            bad++; $display("FAIL reset_outputs: got %h, want 0", outs);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        total++;
        if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
            bad++; $display("FAIL idle_after_reset: busy=%b valid=%b, want 0 0", bus.busy, bus.out_valid);
        end
    endtask

    task automatic test_continuous();
        int e;
        start_frame(1'b1);
        total++;
        if (bus.rmem_id !== 1'b1 || bus.busy !== 1'b1) begin
            bad++; $display("FAIL cont_latch: rmem_id=%b busy=%b, want 1 1", bus.rmem_id, bus.busy);
        end
        consume(0, 200, -1, 0);
        total++;
        if (first_valid_cyc !== 3) begin
            bad++; $display("FAIL cont_latency: got %0d, want 3", first_valid_cyc);
        end
        e = beat_errors(1);
        total++;
        if (e !== 0) begin
            bad++; $display("FAIL cont_beats: %0d errors, want 0", e);
        end
        total++;
        if (last_hs_cyc !== 10) begin
            bad++; $display("FAIL cont_throughput: last beat cycle %0d, want 10", last_hs_cyc);
        end
        total++;
        if (done_seen !== 1 || done_cyc !== last_hs_cyc + 1 || bus.busy !== 1'b0) begin
            bad++; $display("FAIL cont_done: seen=%0d cyc=%0d busy=%b, want 1 %0d 0",
                            done_seen, done_cyc, bus.busy, last_hs_cyc + 1);
        end
        @(posedge clk); #1;
        total++;
        if (bus.done !== 1'b0 || bus.rmem_id !== 1'b1) begin
            bad++; $display("FAIL cont_after_done: done=%b rmem_id=%b, want 0 1", bus.done, bus.rmem_id);
        end
    endtask

    task automatic test_toggle();
        int e;
        logic bank;
        bank = 1'($urandom_range(0, 1));
        start_frame(bank);
        consume(1, 300, -1, 0);
        e = beat_errors(int'(bank));
        total++;
        if (e !== 0 || done_seen !== 1) begin
            bad++; $display("FAIL toggle_beats: errors=%0d done=%0d, want 0 1", e, done_seen);
        end
        total++;
        if (stall_err !== 0 || outst_err !== 0) begin
            bad++; $display("FAIL toggle_stall: stall=%0d overrun=%0d, want 0 0", stall_err, outst_err);
        end
    endtask

    task automatic test_backpressure();
        int e;
        start_frame(1'b0);
        consume(3, 300, -1, 0);
        total++;
        if (rd_at20 !== DEPTH || rea_at20 !== 0) begin
            bad++; $display("FAIL bp_credit: reads=%0d rea=%0d, want %0d 0", rd_at20, rea_at20, DEPTH);
        end
        e = beat_errors(0);
        total++;
        if (e !== 0 || done_seen !== 1 || stall_err !== 0) begin
            bad++; $display("FAIL bp_beats: errors=%0d done=%0d stall=%0d, want 0 1 0", e, done_seen, stall_err);
        end
    endtask

    task automatic test_restart_ignored();
        int e;
        start_frame(1'b1);
        consume(2, 300, 5, 0);
        e = beat_errors(1);
        total++;
        if (e !== 0 || bus.rmem_id !== 1'b1) begin
            bad++; $display("FAIL restart_ignored: errors=%0d rmem_id=%b, want 0 1", e, bus.rmem_id);
        end
        total++;
        if (rd_count - rd_base !== BEATS || done_seen !== 1) begin
            bad++; $display("FAIL restart_reads: reads=%0d done=%0d, want %0d 1", rd_count - rd_base, done_seen, BEATS);
        end
    endtask

    task automatic test_reset_mid();
        int e, dn;
        logic [3*AW+2*DW+6:0] outs;
        start_frame(1'b1);
        consume(0, 200, -1, 4);
        rst = 1'b1;
        @(posedge clk); #1;
        outs = {bus.rmem_id, bus.fft_raddra, bus.fft_raddrb, bus.fft_rea, bus.fft_reb,
                bus.out_dataa, bus.out_datab, bus.out_valid, bus.out_last, bus.busy, bus.done, AW'(0)};
        total++;
        if (outs !== '0) begin
            bad++; $display("FAIL midreset_outputs: got %h, want 0", outs);
        end
        rst = 1'b0;
        dn = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (bus.done) dn++;
        end
        total++;
        if (dn !== 0) begin
            bad++; $display("FAIL midreset_no_done: got %0d pulses, want 0", dn);
        end
        start_frame(1'b0);
        consume(2, 300, -1, 0);
        e = beat_errors(0);
        total++;
        if (e !== 0 || first_valid_cyc !== 3 || done_seen !== 1) begin
            bad++; $display("FAIL midreset_fresh: errors=%0d latency=%0d done=%0d, want 0 3 1",
                            e, first_valid_cyc, done_seen);
        end
    endtask

    task automatic test_random_frames();
        int e;
        logic bank;
        for (int f = 0; f < 4; f++) begin
            bank = 1'($urandom_range(0, 1));
            start_frame(bank);
            consume(2, 400, -1, 0);
            e = beat_errors(int'(bank));
            total++;
            if (e !== 0 || done_seen !== 1 || stall_err !== 0 || outst_err !== 0) begin
                bad++; $display("FAIL random_frame%0d: errors=%0d done=%0d stall=%0d overrun=%0d, want 0 1 0 0",
                                f, e, done_seen, stall_err, outst_err);
            end
        end
        total++;
        if (en_split !== 0) begin
            bad++; $display("FAIL enables_paired: %0d split cycles, want 0", en_split);
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.mem_sel = 1'b0;
        bus.out_ready = 1'b0;
        for (int b = 0; b < 2; b++) begin
            for (int a = 0; a < FFT_SIZE; a++) begin
                mem[b][a] = $urandom;
            end
        end
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_continuous();
        test_toggle();
        test_backpressure();
        test_restart_ignored();
        test_reset_mid();
        test_random_frames();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
